ascii_keystroke_sequencer: RTL and testbench

Converts a stream of ASCII bytes from the UART deserializer into complete PS/2 Set-2 keystroke byte sequences (make, break, and shift wrapping where needed) and feeds them one byte at a time to the PS/2 device-side transmitter. It sits between `async_receiver` (upstream) and `ps2_send` (downstream). It replaces single-byte scancode injection with a buffered, full press/release emulator, so host-side terminals can paste text.

---
 rtl/ps2_kbd_pkg.sv | 51 +++++
 rtl/ascii_to_scancode.sv | 94 +++++++++
 rtl/ascii_keystroke_sequencer.sv | 157 +++++++++++++++
 tb/tb_ascii_keystroke_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the ASCII-to-PS/2 keystroke path.
//   kbd_state_t  : sequencer FSM states
//   scan_map_t   : lookup result {supported, shift, code}
//   seq_byte()   : byte emitted at a given step of a keystroke sequence
//   last_step()  : final step index for shifted / unshifted keys
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;
  localparam logic [7:0] PS2_SPACE  = 8'h29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ISSUE,
    ST_ARM,
    ST_DRAIN,
    ST_GAP
  } kbd_state_t;

  typedef struct packed {
    logic       supported;
    logic       shift;
    logic [7:0] code;
  } scan_map_t;

  // Unshifted: code, F0, code.  Shifted: 12, code, F0, code, F0, 12.
  function automatic logic [7:0] seq_byte(input logic       shift,
                                          input logic [7:0] code,
                                          input logic [2:0] step);
    logic [7:0] b;
    b = code;
    if (shift) begin
      case (step)
        3'd0:       b = PS2_LSHIFT;
        3'd1, 3'd3: b = code;
        3'd2, 3'd4: b = PS2_BREAK;
        default:    b = PS2_LSHIFT;
      endcase
    end else if (step == 3'd1) begin
      b = PS2_BREAK;
    end
    return b;
  endfunction

  function automatic logic [2:0] last_step(input logic shift);
    return shift ? 3'd5 : 3'd2;
  endfunction

endpackage

// File: rtl/ascii_to_scancode.sv
// Combinational ROM: ASCII byte -> PS/2 Set-2 make code.
//   ascii : input byte
//   map   : {supported, shift, code}; unsupported bytes return all zeros
import ps2_kbd_pkg::*;

module ascii_to_scancode (
  input  logic [7:0] ascii,
  output scan_map_t  map
);

  logic [7:0] lc;
  logic       is_upper;
  logic       is_lower;

  always_comb begin
    map      = '0;
    lc       = ascii | 8'h20;
    is_upper = (ascii >= 8'h41) && (ascii <= 8'h5A);
    is_lower = (ascii >= 8'h61) && (ascii <= 8'h7A);
    if (is_upper || is_lower) begin
      // Letters share one key table; case only selects shift.
      map.supported = 1'b1;
      map.shift     = is_upper;
      case (lc)
        8'h61: map.code = 8'h1C;  8'h62: map.code = 8'h32;
        8'h63: map.code = 8'h21;  8'h64: map.code = 8'h23;
        8'h65: map.code = 8'h24;  8'h66: map.code = 8'h2B;
        8'h67: map.code = 8'h34;  8'h68: map.code = 8'h33;
        8'h69: map.code = 8'h43;  8'h6A: map.code = 8'h3B;
        8'h6B: map.code = 8'h42;  8'h6C: map.code = 8'h4B;
        8'h6D: map.code = 8'h3A;  8'h6E: map.code = 8'h31;
        8'h6F: map.code = 8'h44;  8'h70: map.code = 8'h4D;
        8'h71: map.code = 8'h15;  8'h72: map.code = 8'h2D;
        8'h73: map.code = 8'h1B;  8'h74: map.code = 8'h2C;
        8'h75: map.code = 8'h3C;  8'h76: map.code = 8'h2A;
        8'h77: map.code = 8'h1D;  8'h78: map.code = 8'h22;
        8'h79: map.code = 8'h35;  8'h7A: map.code = 8'h1A;
        default: map.code = 8'h00;
      endcase
    end else begin
      case (ascii)
        // digits
        8'h30: map = '{1'b1, 1'b0, 8'h45};
        8'h31: map = '{1'b1, 1'b0, 8'h16};
        8'h32: map = '{1'b1, 1'b0, 8'h1E};
        8'h33: map = '{1'b1, 1'b0, 8'h26};
        8'h34: map = '{1'b1, 1'b0, 8'h25};
        8'h35: map = '{1'b1, 1'b0, 8'h2E};
        8'h36: map = '{1'b1, 1'b0, 8'h36};
        8'h37: map = '{1'b1, 1'b0, 8'h3D};
        8'h38: map = '{1'b1, 1'b0, 8'h3E};
        8'h39: map = '{1'b1, 1'b0, 8'h46};
        // unshifted punctuation
        8'h60: map = '{1'b1, 1'b0, 8'h0E};
        8'h2D: map = '{1'b1, 1'b0, 8'h4E};
        8'h3D: map = '{1'b1, 1'b0, 8'h55};
        8'h5B: map = '{1'b1, 1'b0, 8'h54};
        8'h5D: map = '{1'b1, 1'b0, 8'h5B};
        8'h3B: map = '{1'b1, 1'b0, 8'h4C};
        8'h27: map = '{1'b1, 1'b0, 8'h52};
        8'h2C: map = '{1'b1, 1'b0, 8'h41};
        8'h2E: map = '{1'b1, 1'b0, 8'h49};
        8'h2F: map = '{1'b1, 1'b0, 8'h4A};
        8'h5C: map = '{1'b1, 1'b0, 8'h5D};
        8'h20: map = '{1'b1, 1'b0, PS2_SPACE};
        8'h0D: map = '{1'b1, 1'b0, PS2_ENTER};
        // shifted symbols reuse their base key's code
        8'h21: map = '{1'b1, 1'b1, 8'h16};
        8'h40: map = '{1'b1, 1'b1, 8'h1E};
        8'h23: map = '{1'b1, 1'b1, 8'h26};
        8'h24: map = '{1'b1, 1'b1, 8'h25};
        8'h25: map = '{1'b1, 1'b1, 8'h2E};
        8'h5E: map = '{1'b1, 1'b1, 8'h36};
        8'h26: map = '{1'b1, 1'b1, 8'h3D};
        8'h2A: map = '{1'b1, 1'b1, 8'h3E};
        8'h28: map = '{1'b1, 1'b1, 8'h46};
        8'h29: map = '{1'b1, 1'b1, 8'h45};
        8'h5F: map = '{1'b1, 1'b1, 8'h4E};
        8'h2B: map = '{1'b1, 1'b1, 8'h55};
        8'h7B: map = '{1'b1, 1'b1, 8'h54};
        8'h7D: map = '{1'b1, 1'b1, 8'h5B};
        8'h3A: map = '{1'b1, 1'b1, 8'h4C};
        8'h22: map = '{1'b1, 1'b1, 8'h52};
        8'h3C: map = '{1'b1, 1'b1, 8'h41};
        8'h3E: map = '{1'b1, 1'b1, 8'h49};
        8'h3F: map = '{1'b1, 1'b1, 8'h4A};
        8'h7E: map = '{1'b1, 1'b1, 8'h0E};
        8'h7C: map = '{1'b1, 1'b1, 8'h5D};
        default: map = '0;
      endcase
    end
  end

endmodule

// File: rtl/ascii_keystroke_sequencer.sv
// Buffers ASCII bytes and replays each as a PS/2 Set-2 make/break sequence
// (with left-shift wrapping when needed), one byte per request to ps2_send.
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid, rx_data   : ASCII byte strobe from the UART receiver
//   tx_req, tx_data     : one-cycle request + scancode byte to ps2_send
//   tx_busy             : ps2_send frame in progress
//   fifo_full, overflow : buffer full / sticky dropped-byte flag
//   idle                : buffer empty and no sequence in progress
import ps2_kbd_pkg::*;

module ascii_keystroke_sequencer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_CYCLES  = 25000,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       idle
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (GAP_CYCLES > ARM_TIMEOUT) ? GAP_CYCLES : ARM_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_pop;
  logic             do_write;

  kbd_state_t       state;
  logic [7:0]       char_q;
  logic             shift_q;
  logic [7:0]       code_q;
  logic [2:0]       step;
  logic [TMR_W-1:0] timer;
  scan_map_t        map;

  ascii_to_scancode u_lookup (
    .ascii (char_q),
    .map   (map)
  );

  // A pop in the same cycle frees a slot, so a write while full is still taken.
  always_comb begin
    do_pop    = (state == ST_IDLE) && (count != '0);
    do_write  = rx_valid && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    count_nxt = count + CNT_W'(do_write) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_write) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      fifo_full <= (count_nxt == CNT_W'(FIFO_DEPTH));
      if (rx_valid && !do_write) overflow <= 1'b1;
    end
  end

  // tx_req/tx_data are loaded on the edge that enters ISSUE, so the request
  // is visible during the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_req  <= 1'b0;
      tx_data <= 8'h00;
      idle    <= 1'b1;
      step    <= 3'd0;
      timer   <= '0;
    end else begin
      tx_req <= 1'b0;
      idle   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_pop) begin
            char_q <= fifo_mem[rd_ptr];
            state  <= ST_LOOKUP;
          end else begin
            idle <= (count_nxt == '0);
          end
        end
        ST_LOOKUP: begin
          shift_q <= map.shift;
          code_q  <= map.code;
          if (map.supported) begin
            step    <= 3'd0;
            tx_req  <= 1'b1;
            tx_data <= seq_byte(map.shift, map.code, 3'd0);
            state   <= ST_ISSUE;
          end else begin
            idle  <= (count_nxt == '0);
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_ARM;
        end
        ST_ARM: begin
          if (tx_busy) begin
            state <= ST_DRAIN;
          end else if (timer == TMR_W'(ARM_TIMEOUT - 1)) begin
            timer <= '0;
            state <= ST_GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            timer <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer == TMR_W'(GAP_CYCLES - 1)) begin
            timer <= '0;
            if (step == last_step(shift_q)) begin
              idle  <= (count_nxt == '0);
              state <= ST_IDLE;
            end else begin
              step    <= step + 3'd1;
              tx_req  <= 1'b1;
              tx_data <= seq_byte(shift_q, code_q, step + 3'd1);
              state   <= ST_ISSUE;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_keystroke_sequencer.sv
// Bench for ascii_keystroke_sequencer: directed ASCII stimulus, a keystroke
// model built from key tables, and a per-cycle checker on tx_req/tx_data.
module tb_ascii_keystroke_sequencer;

  localparam int FIFO_DEPTH  = 16;
  localparam int GAP_CYCLES  = 20;
  localparam int ARM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;
  logic       idle;

  logic busy_hold  = 1'b0;
  logic busy_pulse = 1'b0;
  int   busy_mode  = 1;    // 0: never busy, 1: pulse after each request, 2: none
  int   busy_len   = 100;
  assign tx_busy = busy_hold | busy_pulse;

  ascii_keystroke_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .GAP_CYCLES  (GAP_CYCLES),
    .ARM_TIMEOUT (ARM_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Key tables for the model
  bit         tab_ok    [256];
  bit         tab_shift [256];
  logic [7:0] tab_code  [256];
  logic [7:0] lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pcode [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h5D};

  task automatic add_key(input int c, input bit sh, input logic [7:0] code);
    tab_ok[c] = 1'b1; tab_shift[c] = sh; tab_code[c] = code;
  endtask

  task automatic build_tables();
    string lower = "abcdefghijklmnopqrstuvwxyz";
    string digs  = "0123456789";
    string sdigs = ")!@#$%^&*(";
    string punc  = "`-=[];',./\\";
    string spunc = "~_+{}:\"<>?|";
    for (int i = 0; i < 256; i++) begin tab_ok[i] = 0; tab_shift[i] = 0; tab_code[i] = 0; end
    for (int i = 0; i < 26; i++) begin
      add_key(int'(lower[i]), 1'b0, lcode[i]);
      add_key(int'(lower[i]) - 32, 1'b1, lcode[i]);
    end
    for (int i = 0; i < 10; i++) begin
      add_key(int'(digs[i]), 1'b0, dcode[i]);
      add_key(int'(sdigs[i]), 1'b1, dcode[i]);
    end
    for (int i = 0; i < 11; i++) begin
      add_key(int'(punc[i]), 1'b0, pcode[i]);
      add_key(int'(spunc[i]), 1'b1, pcode[i]);
    end
    add_key(32, 1'b0, 8'h29);
    add_key(13, 1'b0, 8'h5A);
  endtask

  logic [7:0] exp_q    [$];
  logic [7:0] got_log  [$];
  int         req_times[$];
  int         send_cyc;
  bit         chk_stable = 1'b0;

  task automatic model_push(input logic [7:0] b);
    logic [7:0] k;
    if (tab_ok[b]) begin
      k = tab_code[b];
      if (tab_shift[b]) begin
        exp_q.push_back(8'h12); exp_q.push_back(k); exp_q.push_back(8'hF0);
        exp_q.push_back(k);     exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
      end else begin
        exp_q.push_back(k); exp_q.push_back(8'hF0); exp_q.push_back(k);
      end
    end
  endtask

  // Called on a falling edge; returns one falling edge later.
  task automatic send_byte(input logic [7:0] b, input bit accepted);
    rx_valid = 1'b1;
    rx_data  = b;
    send_cyc = cyc;
    if (accepted) model_push(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    repeat (4) @(negedge clk);
    n = 0;
    while (!(idle && exp_q.size() == 0 && !tx_busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) begin
      tests++; fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
    end
  endtask

  task automatic check_log(input string name, input logic [47:0] e, input int n);
    check({name, "_len"}, got_log.size(), n);
    for (int i = 0; i < n && i < got_log.size(); i++)
      check({name, "_byte"}, got_log[i], e[(n-1-i)*8 +: 8]);
    got_log.delete();
  endtask

  // Checker: every request must be the next modelled byte; tx_data holds between requests.
  initial begin
    logic [7:0] last_data;
    int         prev_req;
    bit         have_prev;
    last_data = 8'h00;
    have_prev = 1'b0;
    prev_req  = 0;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        req_times.push_back(cyc);
        got_log.push_back(tx_data);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_tx_req: got tx_data %0h, required no request", tx_data);
        end else begin
          check("tx_data_seq", tx_data, exp_q.pop_front());
        end
        if (have_prev && chk_stable) begin
          tests++;
          if (cyc - prev_req < GAP_CYCLES + 2) begin
            fails++;
            $display("FAIL req_spacing: got %0d cycles, required at least %0d", cyc - prev_req, GAP_CYCLES + 2);
          end
        end
        prev_req  = cyc;
        have_prev = 1'b1;
        last_data = tx_data;
      end else if (!chk_stable) begin
        last_data = tx_data;
      end else begin
        check("tx_data_hold", tx_data, last_data);
      end
    end
  end

  // ps2_send stand-in
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req && busy_mode == 1) begin
        repeat (2) @(posedge clk);
        #1 busy_pulse = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy_pulse = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    string burst;
    int    n;
    build_tables();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idle", idle, 1);
    chk_stable = 1'b1;

    // 'a' with 100-cycle frames; first request 3 cycles after the strobe
    req_times.delete();
    send_byte(8'h61, 1);
    wait_idle("a", 5000);
    check("a_latency", (req_times.size() > 0) ? req_times[0] - send_cyc : -1, 3);
    check_log("a_seq", 48'h1CF01C, 3);

    busy_len = 10;
    send_byte(8'h41, 1);
    wait_idle("A", 5000);
    check_log("A_seq", 48'h121CF01CF012, 6);

    send_byte(8'h7E, 1);
    wait_idle("tilde", 5000);
    check_log("tilde_seq", 48'h120EF00EF012, 6);

    send_byte(8'h0D, 1);
    wait_idle("cr", 5000);
    check_log("cr_seq", 48'h5AF05A, 3);

    // Unsupported bytes: no request, idle back on the third cycle
    send_byte(8'h07, 1);
    check("bel_not_idle", idle, 0);
    repeat (2) @(negedge clk);
    check("bel_idle_back", idle, 1);
    send_byte(8'h0A, 1);
    repeat (2) @(negedge clk);
    check("lf_idle_back", idle, 1);
    repeat (10) @(negedge clk);
    check("unsupported_no_req", got_log.size(), 0);

    // tx_busy never rises: each request advances on the arm timeout
    busy_mode = 0;
    req_times.delete();
    send_byte(8'h62, 1);
    wait_idle("timeout", 5000);
    check_log("timeout_seq", 48'h32F032, 3);
    for (int i = 0; i + 1 < req_times.size(); i++) begin
      n = req_times[i+1] - req_times[i];
      tests++;
      if (n < ARM_TIMEOUT + GAP_CYCLES || n > ARM_TIMEOUT + GAP_CYCLES + 2) begin
        fails++;
        $display("FAIL timeout_spacing: got %0d cycles, required %0d..%0d", n,
                 ARM_TIMEOUT + GAP_CYCLES, ARM_TIMEOUT + GAP_CYCLES + 2);
      end
    end

    // Overflow: frame stuck busy, 17 accepted, 18th dropped
    busy_mode = 2;
    busy_hold = 1'b1;
    burst = "abcdefghijklmnopq";
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1;
      rx_data  = burst[i];
      model_push(burst[i]);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("burst17_full", fifo_full, 1);
    check("burst17_no_overflow", overflow, 0);
    send_byte(8'h72, 0);
    check("drop18_overflow", overflow, 1);
    check("drop18_full", fifo_full, 1);
    repeat (5) @(negedge clk);
    check("overflow_sticky", overflow, 1);
    busy_len  = 5;
    busy_mode = 1;
    busy_hold = 1'b0;
    wait_idle("burst", 20000);
    check("burst_bytes", got_log.size(), 51);
    check("burst_overflow_kept", overflow, 1);
    check("burst_not_full", fifo_full, 0);
    got_log.delete();

    // Reset during the fourth byte of 'A' with more characters queued
    busy_len = 10;
    send_byte(8'h41, 1);
    send_byte(8'h78, 1);
    send_byte(8'h79, 1);
    n = 0;
    while (got_log.size() < 4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reset_reached_step3", got_log.size() >= 4, 1);
    chk_stable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    got_log.delete();
    check("midrst_tx_req", tx_req, 0);
    check("midrst_idle", idle, 1);
    check("midrst_overflow", overflow, 0);
    check("midrst_fifo_full", fifo_full, 0);
    check("midrst_tx_data", tx_data, 8'h00);
    repeat (3) @(negedge clk);
    chk_stable = 1'b1;
    repeat (200) @(negedge clk);
    check("midrst_still_idle", idle, 1);
    check("midrst_no_req", got_log.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
